// File: rtl/demux1x8_deser.sv
// Serial-to-parallel receiver: routes each valid bit through a 1-to-8 demux into an
// assembly register and hands completed bytes to a one-entry valid/ready buffer.
module demux1x8_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       in_valid,
    input  logic       sync,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] idx,
    output logic       overrun
);

    logic [7:0] asm_reg;
    logic [7:0] asm_next;
    logic [7:0] byte_done;
    logic       complete;
    logic       pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        asm_next  = asm_reg;
        complete  = 1'b0;
        pop       = out_valid && out_ready;
        byte_done = {in, asm_reg[6:0]};
        if (in_valid) begin
            if (sync) begin
                asm_next[0] = in;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (idx == 3'(k)) begin
                        asm_next[k] = in;
                    end
                end
                complete = (idx == 3'd7);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_reg   <= 8'h00;
            idx       <= 3'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            asm_reg <= asm_next;
            if (in_valid) begin
                idx <= sync ? 3'd1 : idx + 3'd1;
            end

            // A pop in the same cycle frees the slot, so the new byte loads without a bubble.
            if (complete && (!out_valid || pop)) begin
                out       <= byte_done;
                out_valid <= 1'b1;
            end else if (complete) begin
                overrun   <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux1x8_deser.sv
// Self-checking bench for demux1x8_deser: expected bytes are queued as they are sent
// and compared whenever the DUT hands a byte over through the valid/ready handshake.
module tb_demux1x8_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] idx;
    logic       overrun;

    int checks = 0;
    int passes = 0;
    logic [7:0] sb_q[$];

    demux1x8_deser dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .in_valid (in_valid),
        .sync     (sync),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .idx      (idx),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            passes++;
    endtask

    // Scoreboard side: every accepted byte must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0)
                check("unexpected_byte", {24'h0, out}, 32'h100);
            else
                check("byte", {24'h0, out}, {24'h0, sb_q.pop_front()});
        end
    end

    task automatic send_bit(input logic b, input logic s);
        in       = b;
        sync     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        sync     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s_first);
        for (int i = 0; i < 8; i++)
            send_bit(b[i], (i == 0) && s_first);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat[5];
        logic [7:0] b;
        pat = '{8'h01, 8'h22, 8'h05, 8'h80, 8'hEF};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {24'h0, out}, 32'h00);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_idx", {29'h0, idx}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Single byte A5, sync on first bit
        sb_q.push_back(8'hA5);
        b = 8'hA5;
        send_bit(b[0], 1'b1);
        check("idx_after_first", {29'h0, idx}, 32'h1);
        for (int i = 1; i < 8; i++) send_bit(b[i], 1'b0);
        check("a5_out", {24'h0, out}, 32'hA5);
        check("a5_valid", {31'h0, out_valid}, 32'h1);
        check("a5_idx", {29'h0, idx}, 32'h0);
        idle(1);
        check("a5_one_cycle", {31'h0, out_valid}, 32'h0);

        // Back-to-back bytes with continuous in_valid
        for (int n = 0; n < 5; n++) begin
            sb_q.push_back(pat[n]);
            send_byte(pat[n], n == 0);
            check("b2b_out", {24'h0, out}, {24'h0, pat[n]});
            check("b2b_valid", {31'h0, out_valid}, 32'h1);
        end
        send_bit(1'b0, 1'b1);
        check("b2b_gap", {31'h0, out_valid}, 32'h0);
        check("b2b_overrun", {31'h0, overrun}, 32'h0);
        idle(2);

        // Partial byte discarded by sync
        for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0);
        check("partial_no_out", {31'h0, out_valid}, 32'h0);
        sb_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        check("sync_out", {24'h0, out}, 32'h3C);
        idle(2);

        // Overrun with a stalled consumer
        out_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(1);
        check("ovr_held", {24'h0, out}, 32'h11);
        check("ovr_valid", {31'h0, out_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        out_ready = 1'b1;
        idle(1);
        check("ovr_popped", {31'h0, out_valid}, 32'h0);
        check("ovr_out_holds", {24'h0, out}, 32'h11);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);

        // Pop and completion in the same cycle
        out_ready = 1'b0;
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        b = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(b[i], 1'b0);
        check("sim_hold", {24'h0, out}, 32'h11);
        out_ready = 1'b1;
        send_bit(b[7], 1'b0);
        check("sim_out", {24'h0, out}, 32'h22);
        check("sim_valid", {31'h0, out_valid}, 32'h1);
        check("sim_overrun", {31'h0, overrun}, 32'h0);
        idle(2);

        // Reset mid-byte with a pending output
        out_ready = 1'b0;
        send_byte(8'h5A, 1'b1);
        b = 8'h96;
        for (int i = 0; i < 5; i++) send_bit(b[i], i == 0);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_out", {24'h0, out}, 32'h00);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_idx", {29'h0, idx}, 32'h0);
        check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        out_ready = 1'b1;
        sb_q.push_back(8'h96);
        send_byte(8'h96, 1'b0);
        check("post_rst_out", {24'h0, out}, 32'h96);
        idle(3);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/demux1x8_deser.md
# demux1x8_deser

Serial-to-parallel receiver for the 8:1 mux serializer path. It takes one data bit per valid cycle and routes it with a 1-to-8 demultiplexer into bit position `idx` of an assembly register, using a 3-bit index counter that mirrors the serializer's `sel` sequence (0..7). It presents each completed byte on a one-entry valid/ready output buffer. It sits at the far end of a serial link whose transmitter steps `sel` from 0 to 7, so bit k of the transmitted byte always lands in `out[k]`.

## Interface
- No parameters; width fixed at 8 bits, index 3 bits.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in`  input  1  serial data bit.
- `in_valid`  input  1  `in` is a valid bit this cycle.
- `sync`  input  1  qualified by `in_valid`; marks this bit as bit 0 of a new byte.
- `out`  output  8  assembled byte (bit k = k-th received bit).
- `out_valid`  output  1  `out` holds an unconsumed byte.
- `out_ready`  input  1  consumer accepts `out` when `out_valid` is also high.
- `idx`  output  3  index the next valid bit will be written to.
- `overrun`  output  1  sticky; a completed byte was dropped.

## Operation
- Reset values: `out`=8'h00, `out_valid`=0, `idx`=0, `overrun`=0, assembly register=8'h00.
- Bit write on `in_valid`=1:
  - `sync`=0: `asm[idx]` <= `in`; `idx` <= `idx`+1, wrapping modulo 8 (7 -> 0).
  - `sync`=1: the partial byte is discarded. `asm[0]` <= `in`; `idx` <= 1.
- `in_valid`=0: `asm` and `idx` hold. `sync` is ignored.
- Byte completion occurs when `in_valid`=1, `sync`=0, and `idx`=7. The completed byte is `{in, asm[6:0]}`.
- Output buffer (one entry):
  - Pop when `out_valid` && `out_ready`.
  - On completion, if the buffer is empty or popping this cycle: `out` <= completed byte and `out_valid` <= 1.
  - On completion while the buffer is full and not popping: the byte is dropped, `out`/`out_valid` are unchanged, and `overrun` <= 1.
  - Pop with no completion: `out_valid` <= 0 and `out` holds its last value.
- `overrun` clears only on `rst`.
- Sync precedence: `sync`=1 with `idx`=7 produces no byte; sync wins.

## Timing
- Latency: the completing bit is sampled at edge N, and `out`/`out_valid` are visible after edge N (cycle N+1).
- Back-to-back bytes with continuous `in_valid`: a byte completes every 8 cycles. A consumer that keeps `out_ready` high never causes overrun.
- Simultaneous pop and completion in the same cycle: the new byte is loaded, `out_valid` stays 1 with no bubble, and `overrun` stays unchanged.
- `out` is stable while `out_valid`=1 and `out_ready`=0.
- `rst` mid-byte: the partial byte is lost, `idx`=0 on the next cycle, and any pending output is discarded.
- `idx` updates one cycle after each valid bit and is purely registered.

## Test plan
- Reset, then send 8'hA5 LSB-first (bits 1,0,1,0,0,1,0,1), `sync`=1 on the first bit, `out_ready`=1 -> one cycle after the 8th bit: `out`=8'hA5, `out_valid`=1 for exactly one cycle, `idx`=0.
- Send 8'h01, 8'h22, 8'h05, 8'h80, 8'hEF back-to-back with continuous `in_valid` and `out_ready`=1 -> five `out_valid` pulses spaced 8 cycles apart carrying those values in order, `overrun`=0.
- Send 3 bits of 8'hFF, then assert `sync` and send 8'h3C -> only 8'h3C is output; no byte from the partial.
- `out_ready`=0, send 8'h11 then 8'h22 -> `out`=8'h11 held, `overrun`=1 after the 2nd byte; raising `out_ready` pops 8'h11 and `out_valid` then drops.
- Hold `out_ready`=0 across the 8'h11 completion, then raise it in the same cycle 8'h22 completes -> `out`=8'h22 next cycle, `out_valid` stays 1, `overrun`=0.
- Pulse `rst` after 5 bits with `out_valid`=1 -> all outputs at reset values next cycle; a following full 8'h96 (no `sync`) is output correctly.
